ram_burst_sequencer: RTL and testbench
======================================

# ram_burst_sequencer

Sequencer between the granted side of the shared-RAM arbiter and a single-port synchronous RAM. It accepts one burst command at a time: read or write, start address, and length. It then drives one RAM access per cycle with an incrementing address. Read data is returned with a fixed latency. Write data is taken through a valid/ready handshake, guarded by a stall watchdog.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, 8, RAM data width
- LEN_WIDTH, 4, burst length field width; a burst is cmd_len+1 beats (1..16)
- WD_TIMER_WIDTH, 6, write-stall watchdog counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - reset  in  1  synchronous active-high reset
- Command:
  - cmd_valid  in  1  command present
  - cmd_ready  out  1  sequencer accepts command (high only in IDLE)
  - cmd_rdwrn  in  1  1 = read burst, 0 = write burst
  - cmd_addr  in  ADDR_WIDTH  start address
  - cmd_len  in  LEN_WIDTH  beats minus one
- Write data:
  - wr_valid  in  1  write beat present
  - wr_ready  out  1  write beat accepted
  - wr_data  in  DATA_WIDTH  write beat data
- Read response:
  - rd_valid  out  1  read beat valid (no backpressure)
  - rd_data  out  DATA_WIDTH  read beat data
  - rd_last  out  1  final read beat
- Status:
  - done  out  1  one-cycle pulse, burst completed
  - err  out  1  one-cycle pulse, write burst aborted by watchdog
- RAM port:
  - ram_en  out  1  RAM access strobe
  - ram_we  out  1  write enable (valid with ram_en)
  - ram_addr  out  ADDR_WIDTH  RAM address
  - ram_wrdata  out  DATA_WIDTH  RAM write data
  - ram_rddata  in  DATA_WIDTH  RAM read data, 1 cycle after read strobe

## Operation
- States:
  - stIDLE: cmd_ready=1. A command is accepted when cmd_valid&cmd_ready. On accept, latch addr and len, clear the beat counter, then go to stREAD or stWRITE.
  - stREAD: ram_en=1, ram_we=0 every cycle; address increments per beat. After beat cmd_len is issued, go to stDRAIN.
  - stDRAIN: wait for in-flight read data. Leave when rd_last is emitted; done pulses in the same cycle; go to stIDLE.
  - stWRITE: wr_ready=1. Each wr_valid&wr_ready drives ram_en=1, ram_we=1, ram_addr=current, ram_wrdata=wr_data in the same cycle (combinational pass-through). The last beat pulses done and returns to stIDLE.
- Address arithmetic: address is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH (0xFFF+1 → 0x000). The beat counter is LEN_WIDTH wide and compared against the latched len.
- Read path: one delay-line valid/last bit per pipeline stage. rd_data comes from ram_rddata, or from its register when the macro is set.
- Watchdog, active in stWRITE only:
  - Counter increments each cycle with wr_valid=0 and clears on every accepted beat.
  - When the counter is all-ones (63 cycles at default width), err pulses, done is not asserted, remaining beats are dropped, and the state returns to stIDLE. The counter is cleared on exit.
- ram_en/ram_we are never high in stIDLE. Writes and reads never overlap.

## Timing
- Reset values: cmd_ready=0 during reset and 1 the cycle after; all other outputs 0; state stIDLE; in-flight read pipeline flushed.
- Command accept to first RAM strobe: 1 cycle. No cycle is lost between back-to-back read beats.
- Read latency, first strobe to rd_valid: RD_LAT=1 cycle (2 with the macro).
- An N-beat read occupies N cycles of stREAD plus RD_LAT cycles of stDRAIN. The next command is accepted the cycle after done.
- Write throughput is 1 beat/cycle when wr_valid is held high.
- Reset mid-burst: next cycle is stIDLE with no RAM strobe. Pending read beats are discarded with no rd_valid, done, or err.
- A cmd_valid arriving while busy is held off by cmd_ready=0 and is never dropped.

## Configuration
- RAM_RDREG_EN defined:
  - ram_rddata is registered before rd_data; RD_LAT=2.
  - stDRAIN lasts 2 cycles.
- RAM_RDREG_EN undefined: rd_data=ram_rddata combinationally; RD_LAT=1.

## Structure
- Shared package ram_seq_pkg holds the state encoding constants (stIDLE=2'b00, stREAD=2'b01, stWRITE=2'b10, stDRAIN=2'b11) and the RD_LAT constant, selected by RAM_RDREG_EN.
- One sub-module, ram_seq_watchdog: counter with enable/clear and an all-ones timeout output, sized by WD_TIMER_WIDTH.
- FSM, address/beat counters and the read valid pipeline stay in the top level.

## Test plan
- Single write, then single read:
  - Write cmd addr=0x010, len=0, wr_data=0xA5 → one strobe with ram_we=1, addr 0x010; done the same cycle.
  - Read of 0x010 → rd_valid with rd_data=0xA5 and rd_last=1, RD_LAT cycles after the strobe.
- 4-beat read from 0xFFE → ram_addr sequence 0xFFE, 0xFFF, 0x000, 0x001 on consecutive cycles; 4 rd_valid beats; rd_last and done on the 4th.
- 16-beat write (len=0xF) with wr_valid low for 5 cycles mid-burst → no strobes during the gap; all 16 beats written in order; done once; err never asserted.
- Write burst len=3 with wr_valid dropped after 1 beat → err pulses 63 cycles after the last beat; no done; cmd_ready=1 the following cycle.
- Reset asserted on the 2nd cycle of an 8-beat read → no further ram_en, rd_valid, or done; cmd_ready=1 the cycle after reset deasserts.
- cmd_valid held high through a read burst with a second command queued → the second command is accepted exactly the cycle after done. Run with RAM_RDREG_EN both defined and undefined.

Source files
------------

// File: rtl/ram_burst_sequencer_pkg.sv
// Shared definitions for the RAM burst sequencer: FSM state encoding and
// read-path latency. Optional macro RAM_RDREG_EN registers RAM read data
// before it leaves the sequencer, which adds one cycle of read latency.
package ram_seq_pkg;

  typedef enum logic [1:0] {
    stIDLE  = 2'b00,
    stREAD  = 2'b01,
    stWRITE = 2'b10,
    stDRAIN = 2'b11
  } seq_state_t;

`ifdef RAM_RDREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/ram_burst_sequencer_if.sv
// Bundle of the command, write-data, read-response, status and RAM-port
// signals of the burst sequencer. The sequencer uses the slave modport;
// the client and RAM side uses the master modport.
interface ram_burst_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rdwrn;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  done;
  logic                  err;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wrdata;
  logic [DATA_WIDTH-1:0] ram_rddata;

  modport slave (
    input  cmd_valid, cmd_rdwrn, cmd_addr, cmd_len, wr_valid, wr_data, ram_rddata,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
           ram_en, ram_we, ram_addr, ram_wrdata
  );

  modport master (
    output cmd_valid, cmd_rdwrn, cmd_addr, cmd_len, wr_valid, wr_data, ram_rddata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
           ram_en, ram_we, ram_addr, ram_wrdata
  );

endinterface

// File: rtl/ram_burst_sequencer_watchdog.sv
// Write-stall watchdog: counts stalled cycles, clears on demand, and flags
// the stalled cycle that brings the count to all-ones.
module ram_seq_watchdog #(
  parameter int WD_TIMER_WIDTH = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic timeout_o
);

  logic [WD_TIMER_WIDTH-1:0] count_q, count_d;

  // Next count: clear wins over increment
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WD_TIMER_WIDTH'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = en_i & ~clr_i & (&count_d);

endmodule

// File: rtl/ram_burst_sequencer.sv
// Burst sequencer between the arbiter grant side and a single-port
// synchronous RAM. One burst command at a time; reads issue one strobe per
// cycle, writes pass accepted beats straight through to the RAM.
// Optional macro RAM_RDREG_EN: register ram_rddata before rd_data (RD_LAT=2).
module ram_burst_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int LEN_WIDTH      = 4,
  parameter int WD_TIMER_WIDTH = 6
) (
  input logic                  clk,
  input logic                  reset,
  ram_burst_sequencer_if.slave bus
);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;

  logic [RD_LAT-1:0]     rd_vld_q;
  logic [RD_LAT-1:0]     rd_last_q;
  logic                  issue_rd;
  logic                  issue_last;

  logic                  wr_beat;
  logic                  wd_en;
  logic                  wd_clr;
  logic                  wd_timeout;

  logic                  rd_valid_w;
  logic                  rd_last_w;
  logic [DATA_WIDTH-1:0] rd_data_w;
  logic                  cmd_ready_w;
  logic                  wr_ready_w;
  logic                  done_w;
  logic                  err_w;
  logic                  ram_en_w;
  logic                  ram_we_w;
  logic [ADDR_WIDTH-1:0] ram_addr_w;
  logic [DATA_WIDTH-1:0] ram_wrdata_w;

  // Watchdog only counts stalls inside a write burst and is held clear elsewhere
  assign wr_beat = (state_q == stWRITE) & bus.wr_valid;
  assign wd_en   = (state_q == stWRITE) & ~bus.wr_valid;
  assign wd_clr  = (state_q != stWRITE) | wr_beat;

  ram_seq_watchdog #(
    .WD_TIMER_WIDTH(WD_TIMER_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .en_i     (wd_en),
    .clr_i    (wd_clr),
    .timeout_o(wd_timeout)
  );

  // Outputs are forced low while reset is held so a burst cut short by reset
  // produces no strobe or response in the reset cycle itself
  assign rd_valid_w = rd_vld_q[RD_LAT-1] & ~reset;
  assign rd_last_w  = rd_last_q[RD_LAT-1] & ~reset;

  // FSM next state, address/beat updates and RAM/handshake outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    cmd_ready_w  = 1'b0;
    wr_ready_w   = 1'b0;
    done_w       = 1'b0;
    err_w        = 1'b0;
    ram_en_w     = 1'b0;
    ram_we_w     = 1'b0;
    ram_addr_w   = '0;
    ram_wrdata_w = '0;
    issue_rd     = 1'b0;
    issue_last   = 1'b0;
    if (!reset) begin
      case (state_q)
        stIDLE: begin
          cmd_ready_w = 1'b1;
          if (bus.cmd_valid) begin
            addr_d  = bus.cmd_addr;
            len_d   = bus.cmd_len;
            beat_d  = '0;
            state_d = bus.cmd_rdwrn ? stREAD : stWRITE;
          end
        end
        stREAD: begin
          ram_en_w   = 1'b1;
          ram_addr_w = addr_q;
          issue_rd   = 1'b1;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          beat_d     = beat_q + LEN_WIDTH'(1);
          if (beat_q == len_q) begin
            issue_last = 1'b1;
            state_d    = stDRAIN;
          end
        end
        stDRAIN: begin
          if (rd_valid_w && rd_last_w) begin
            done_w  = 1'b1;
            state_d = stIDLE;
          end
        end
        stWRITE: begin
          wr_ready_w = 1'b1;
          if (wd_timeout) begin
            err_w   = 1'b1;
            state_d = stIDLE;
          end else if (bus.wr_valid) begin
            ram_en_w     = 1'b1;
            ram_we_w     = 1'b1;
            ram_addr_w   = addr_q;
            ram_wrdata_w = bus.wr_data;
            addr_d       = addr_q + ADDR_WIDTH'(1);
            beat_d       = beat_q + LEN_WIDTH'(1);
            if (beat_q == len_q) begin
              done_w  = 1'b1;
              state_d = stIDLE;
            end
          end
        end
        default: state_d = stIDLE;
      endcase
    end
  end

  // FSM state and burst bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= stIDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  // Read valid/last delay line, one bit per cycle of read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      rd_vld_q[0]  <= issue_rd;
      rd_last_q[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

`ifdef RAM_RDREG_EN
  logic [DATA_WIDTH-1:0] rddata_q;

  // Retime RAM read data to ease the path out of the RAM
  always_ff @(posedge clk) begin
    if (reset) begin
      rddata_q <= '0;
    end else begin
      rddata_q <= bus.ram_rddata;
    end
  end

  assign rd_data_w = reset ? '0 : rddata_q;
`else
  assign rd_data_w = reset ? '0 : bus.ram_rddata;
`endif

  assign bus.cmd_ready  = cmd_ready_w;
  assign bus.wr_ready   = wr_ready_w;
  assign bus.rd_valid   = rd_valid_w;
  assign bus.rd_last    = rd_last_w;
  assign bus.rd_data    = rd_data_w;
  assign bus.done       = done_w;
  assign bus.err        = err_w;
  assign bus.ram_en     = ram_en_w;
  assign bus.ram_we     = ram_we_w;
  assign bus.ram_addr   = ram_addr_w;
  assign bus.ram_wrdata = ram_wrdata_w;

endmodule

// File: tb/tb_ram_burst_sequencer.sv
// Self-checking bench for ram_burst_sequencer: a table of write-side cycle
// vectors plus hand-written read, watchdog, reset and back-to-back sequences.
module tb_ram_burst_sequencer;

`ifdef RAM_RDREG_EN
  localparam int RDL = 2;
`else
  localparam int RDL = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_burst_sequencer_if bus ();

  ram_burst_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural single-port RAM with one cycle read latency
  logic [7:0] ram_mem [4096];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wrdata;
      else            bus.ram_rddata <= ram_mem[bus.ram_addr];
    end
  end

  // Expected RAM contents, maintained only from the bench's own vectors
  logic [7:0] exp_mem [4096];

  typedef struct {
    logic        cv;
    logic        rw;
    logic [11:0] ca;
    logic [3:0]  cl;
    logic        wv;
    logic [7:0]  wd;
    logic        e_cr;
    logic        e_wr;
    logic        e_en;
    logic        e_we;
    logic [11:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write-phase cycle inside a burst
  function automatic vec_t wcyc(input logic v, input logic [7:0] d, input logic e_en,
                                input logic [11:0] a, input logic dn, input logic er);
    vec_t r;
    r = '{1'b0, 1'b0, 12'h0, 4'h0, v, d, 1'b0, 1'b1, e_en, e_en, a, d, dn, er};
    return r;
  endfunction

  // Idle cycle presenting a command (or nothing) while the sequencer is ready
  function automatic vec_t icyc(input logic cv, input logic rw, input logic [11:0] a,
                                input logic [3:0] l);
    vec_t r;
    r = '{cv, rw, a, l, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0};
    return r;
  endfunction

  task automatic apply_vec(input vec_t v, input string name);
    logic [63:0] act, exp;
    bus.cmd_valid = v.cv;
    bus.cmd_rdwrn = v.rw;
    bus.cmd_addr  = v.ca;
    bus.cmd_len   = v.cl;
    bus.wr_valid  = v.wv;
    bus.wr_data   = v.wd;
    @(negedge clk);
    act = {bus.cmd_ready, bus.wr_ready, bus.ram_en, bus.ram_we,
           v.e_en ? bus.ram_addr : 12'h0, (v.e_en && v.e_we) ? bus.ram_wrdata : 8'h0,
           bus.done, bus.err, bus.rd_valid};
    exp = {v.e_cr, v.e_wr, v.e_en, v.e_we, v.e_en ? v.e_addr : 12'h0,
           (v.e_en && v.e_we) ? v.e_wdata : 8'h0, v.e_done, v.e_err, 1'b0};
    check(name, act, exp);
    if (v.e_en && v.e_we) exp_mem[v.e_addr] = v.e_wdata;
    @(posedge clk);
    #1;
  endtask

  // Read burst; optionally keeps cmd_valid high with a second command queued
  task automatic read_burst(input logic [11:0] a, input logic [3:0] l, input bit queue_next,
                            input logic [11:0] na, input logic [3:0] nl);
    int n;
    logic [63:0] act, exp;
    logic        e_en, e_rv, e_last;
    logic [11:0] e_addr, e_raddr;
    logic [7:0]  e_data;
    n = int'(l) + 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rdwrn = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.wr_valid  = 1'b0;
    @(negedge clk);
    check("rd_accept", {63'h0, bus.cmd_ready}, 64'h1);
    @(posedge clk);
    #1;
    if (queue_next) begin
      bus.cmd_addr = na;
      bus.cmd_len  = nl;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (int c = 1; c <= n + RDL; c++) begin
      e_en    = (c <= n);
      e_addr  = a + 12'(c - 1);
      e_rv    = (c > RDL);
      e_raddr = a + 12'(c - RDL - 1);
      e_data  = e_rv ? exp_mem[e_raddr] : 8'h00;
      e_last  = (c == n + RDL);
      @(negedge clk);
      act = {bus.cmd_ready, bus.ram_en, bus.ram_we, e_en ? bus.ram_addr : 12'h0,
             bus.rd_valid, bus.rd_last, bus.done, bus.err, e_rv ? bus.rd_data : 8'h00};
      exp = {1'b0, e_en, 1'b0, e_en ? e_addr : 12'h0, e_rv, e_last, e_last, 1'b0, e_data};
      check("rd_beat", act, exp);
      @(posedge clk);
      #1;
    end
    $display("read  burst addr=%03h beats=%0d", a, n);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rdwrn = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;

    // Write table: single write, then 4-beat write wrapping past 0xFFF with a stall
    vecs[0] = icyc(1'b1, 1'b0, 12'h010, 4'h0);
    vecs[1] = wcyc(1'b1, 8'hA5, 1'b1, 12'h010, 1'b1, 1'b0);
    vecs[2] = icyc(1'b0, 1'b0, 12'h000, 4'h0);
    vecs[3] = icyc(1'b1, 1'b0, 12'hFFE, 4'h3);
    vecs[4] = wcyc(1'b1, 8'hD4, 1'b1, 12'hFFE, 1'b0, 1'b0);
    vecs[5] = wcyc(1'b1, 8'hA1, 1'b1, 12'hFFF, 1'b0, 1'b0);
    vecs[6] = wcyc(1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0);
    vecs[7] = wcyc(1'b1, 8'hB2, 1'b1, 12'h000, 1'b0, 1'b0);
    vecs[8] = wcyc(1'b1, 8'hC3, 1'b1, 12'h001, 1'b1, 1'b0);
    vecs[9] = icyc(1'b0, 1'b0, 12'h000, 4'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {56'h0, bus.cmd_ready, bus.wr_ready, bus.ram_en, bus.ram_we,
                            bus.rd_valid, bus.rd_last, bus.done, bus.err}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'h0, bus.cmd_ready}, 64'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i], $sformatf("wr_table[%0d]", i));
    end
    $display("write table applied: %0d vectors", 10);

    // Single read of the single write
    read_burst(12'h010, 4'h0, 1'b0, 12'h0, 4'h0);
    apply_vec(icyc(1'b0, 1'b0, 12'h0, 4'h0), "rd1_idle_after");

    // 4-beat wrapping read with a second command held behind it
    read_burst(12'hFFE, 4'h3, 1'b1, 12'h010, 4'h0);
    read_burst(12'h010, 4'h0, 1'b0, 12'h0, 4'h0);
    apply_vec(icyc(1'b0, 1'b0, 12'h0, 4'h0), "queued_idle_after");

    // 16-beat write with a 5-cycle stall after beat 7, then read it back
    apply_vec(icyc(1'b1, 1'b0, 12'h100, 4'hF), "w16_accept");
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        for (int g = 0; g < 5; g++) apply_vec(wcyc(1'b0, 8'h00, 1'b0, 12'h0, 1'b0, 1'b0), "w16_gap");
      end
      apply_vec(wcyc(1'b1, 8'(8'h30 + i), 1'b1, 12'(12'h100 + i), (i == 15), 1'b0), "w16_beat");
    end
    $display("write burst addr=100 beats=16");
    read_burst(12'h100, 4'hF, 1'b0, 12'h0, 4'h0);
    apply_vec(icyc(1'b0, 1'b0, 12'h0, 4'h0), "rd16_idle_after");

    // Watchdog: one beat of a 4-beat write, then the writer goes silent
    apply_vec(icyc(1'b1, 1'b0, 12'h200, 4'h3), "wd_accept");
    apply_vec(wcyc(1'b1, 8'h77, 1'b1, 12'h200, 1'b0, 1'b0), "wd_beat");
    for (int k = 1; k < 63; k++) apply_vec(wcyc(1'b0, 8'h00, 1'b0, 12'h0, 1'b0, 1'b0), "wd_wait");
    apply_vec(wcyc(1'b0, 8'h00, 1'b0, 12'h0, 1'b0, 1'b1), "wd_err");
    apply_vec(icyc(1'b0, 1'b0, 12'h0, 4'h0), "wd_ready_after");
    $display("write burst addr=200 aborted by watchdog");

    // Reset on the second read cycle of an 8-beat read
    bus.cmd_valid = 1'b1;
    bus.cmd_rdwrn = 1'b1;
    bus.cmd_addr  = 12'h300;
    bus.cmd_len   = 4'h7;
    @(negedge clk);
    check("rst_rd_accept", {63'h0, bus.cmd_ready}, 64'h1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_rd_strobe1", {50'h0, bus.ram_en, bus.ram_we, bus.ram_addr}, {50'h0, 2'b10, 12'h300});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_rd_in_reset", {59'h0, bus.cmd_ready, bus.ram_en, bus.rd_valid, bus.done, bus.err}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rst_rd_quiet", {59'h0, bus.cmd_ready, bus.ram_en, bus.rd_valid, bus.done, bus.err},
            64'h10);
      @(posedge clk);
      #1;
    end
    $display("read  burst addr=300 cut by reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
